// File: rtl/mips_pkg.sv
// Shared constants for the multicycle MIPS control path: ALU codes, opcodes, functs, FSM states.
package mips_pkg;

    localparam logic [3:0] AluAnd = 4'b0000;
    localparam logic [3:0] AluAdd = 4'b0010;
    localparam logic [3:0] AluSub = 4'b0110;
    localparam logic [3:0] AluSlt = 4'b0111;
    localparam logic [3:0] AluNor = 4'b1100;
    localparam logic [3:0] AluSll = 4'b1110;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    localparam logic [5:0] FnSll = 6'h00;
    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnAnd = 6'h24;
    localparam logic [5:0] FnNor = 6'h27;
    localparam logic [5:0] FnSlt = 6'h2A;

    typedef enum logic [3:0] {
        StFetch, StDecode, StMemAdr, StMemRd, StMemWb, StMemWr,
        StExec, StRwb, StBranch, StAddiEx, StAddiWb, StJump
    } state_e;

endpackage

// File: rtl/alu_decoder.sv
// R-type funct to ALU control decode; unsupported functs fall back to add and flag invalid.
module alu_decoder
    import mips_pkg::*;
(
    input  logic [5:0] funct_i,
    output logic [3:0] alu_ctrl_o,
    output logic       funct_valid_o
);

    always_comb begin
        alu_ctrl_o    = AluAdd;
        funct_valid_o = 1'b1;
        unique case (funct_i)
            FnAdd:   alu_ctrl_o = AluAdd;
            FnSub:   alu_ctrl_o = AluSub;
            FnAnd:   alu_ctrl_o = AluAnd;
            FnNor:   alu_ctrl_o = AluNor;
            FnSlt:   alu_ctrl_o = AluSlt;
            FnSll:   alu_ctrl_o = AluSll;
            default: funct_valid_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM: Moore datapath controls, ALU code generation and a retire counter.
module mips_multicycle_control
    import mips_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic [3:0]       ALUControl,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic [1:0]       pc_source,
    output logic             pc_write,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] instr_count_q, instr_count_d;
    logic [3:0]       rtype_alu;
    logic             funct_valid;

    alu_decoder u_alu_decoder (
        .funct_i       (funct),
        .alu_ctrl_o    (rtype_alu),
        .funct_valid_o (funct_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StFetch;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            instr_count_q <= instr_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        instr_count_d = instr_count_q;
        ALUControl    = AluAnd;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'd0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        pc_source     = 2'd0;
        pc_write      = 1'b0;
        illegal       = 1'b0;
        // Reset forces every output low; the state register handles the return to fetch.
        if (!reset) begin
            unique case (state_q)
                StFetch: begin
                    mem_read   = 1'b1;
                    ir_write   = 1'b1;
                    alu_src_b  = 2'd1;
                    ALUControl = AluAdd;
                    pc_write   = 1'b1;
                    state_d    = StDecode;
                end
                StDecode: begin
                    alu_src_b  = 2'd3;
                    ALUControl = AluAdd;
                    unique case (opcode)
                        OpRtype:     state_d = StExec;
                        OpLw, OpSw:  state_d = StMemAdr;
                        OpBeq:       state_d = StBranch;
                        OpAddi:      state_d = StAddiEx;
                        OpJ:         state_d = StJump;
                        default: begin
                            illegal = 1'b1;
                            state_d = StFetch;
                        end
                    endcase
                end
                StMemAdr: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = 2'd2;
                    ALUControl = AluAdd;
                    state_d    = (opcode == OpLw) ? StMemRd : StMemWr;
                end
                StMemRd: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                    state_d  = StMemWb;
                end
                StMemWb: begin
                    reg_write     = 1'b1;
                    mem_to_reg    = 1'b1;
                    instr_count_d = instr_count_q + CNT_W'(1);
                    state_d       = StFetch;
                end
                StMemWr: begin
                    mem_write     = 1'b1;
                    iord          = 1'b1;
                    instr_count_d = instr_count_q + CNT_W'(1);
                    state_d       = StFetch;
                end
                StExec: begin
                    alu_src_a  = 1'b1;
                    ALUControl = rtype_alu;
                    illegal    = ~funct_valid;
                    state_d    = funct_valid ? StRwb : StFetch;
                end
                StRwb: begin
                    reg_write     = 1'b1;
                    reg_dst       = 1'b1;
                    instr_count_d = instr_count_q + CNT_W'(1);
                    state_d       = StFetch;
                end
                StBranch: begin
                    alu_src_a     = 1'b1;
                    ALUControl    = AluSub;
                    pc_source     = 2'd1;
                    pc_write      = zero;
                    instr_count_d = instr_count_q + CNT_W'(1);
                    state_d       = StFetch;
                end
                StAddiEx: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = 2'd2;
                    ALUControl = AluAdd;
                    state_d    = StAddiWb;
                end
                StAddiWb: begin
                    reg_write     = 1'b1;
                    instr_count_d = instr_count_q + CNT_W'(1);
                    state_d       = StFetch;
                end
                StJump: begin
                    pc_source     = 2'd2;
                    pc_write      = 1'b1;
                    instr_count_d = instr_count_q + CNT_W'(1);
                    state_d       = StFetch;
                end
                default: state_d = StFetch;
            endcase
        end
    end

    assign instr_count = instr_count_q;

endmodule
